pc_fetch_unit: RTL and testbench

Instruction-fetch stage that sits directly upstream of the instruction decoder.
- Holds the architectural PC and issues word requests to instruction memory using a req/gnt/rvalid handshake.
- Presents the fetched instruction and its PC to decode/execute.
- When execute signals completion, computes the next PC from the NPC operation code produced by the decoder.
- Traps on a misaligned target.

---
 rtl/pc_fetch_unit.sv | 170 +++++++++++++++++
 tb/tb_pc_fetch_unit.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch stage: PC, req/gnt/rvalid fetch, next-PC select, misalign trap.
// Optional counters (cycle/retire/stall) enabled with FETCH_PERF_CNT_EN.
module pc_fetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rstn,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       inst,
    output logic [ADDR_W-1:0] inst_pc,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic              inst_valid,
    input  logic              exec_done,
    input  logic [2:0]        npc_op,
    input  logic [ADDR_W-1:0] imm,
    input  logic [ADDR_W-1:0] rs1_data,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]       cycle_cnt,
    output logic [31:0]       retire_cnt,
    output logic [31:0]       stall_cnt,
`endif
    output logic              trap,
    output logic [ADDR_W-1:0] trap_addr
);

    typedef enum logic [2:0] {
        S_BOOT,
        S_REQ,
        S_WAIT,
        S_ISSUE,
        S_TRAP
    } state_t;

    localparam logic [31:0] NOP = 32'h0000_0013;

    state_t            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_inst_pc;
    logic [31:0]       r_inst;
    logic              r_req;
    logic              r_valid;
    logic              r_trap;
    logic [ADDR_W-1:0] r_trap_addr;

    logic              w_is_br;
    logic              w_is_jalr;
    logic [ADDR_W-1:0] w_jalr_sum;
    logic [ADDR_W-1:0] w_target;
    logic              w_misalign;
    logic              w_capture;

    always_comb begin
        w_is_br    = (npc_op == 3'b001) || (npc_op == 3'b010);
        w_is_jalr  = (npc_op == 3'b100);
        w_jalr_sum = rs1_data + imm;
        w_target   = r_pc + ADDR_W'(4);
        unique case (1'b1)
            w_is_br:   w_target = r_inst_pc + imm;
            w_is_jalr: w_target = {w_jalr_sum[ADDR_W-1:1], 1'b0};
            default:   w_target = r_pc + ADDR_W'(4);
        endcase
        w_misalign = (w_target[1:0] != 2'b00);
    end

    // rvalid only counts alongside gnt in REQ, or in WAIT
    assign w_capture = ((r_state == S_REQ) && imem_gnt && imem_rvalid) ||
                       ((r_state == S_WAIT) && imem_rvalid);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= S_BOOT;
            r_pc        <= RESET_PC;
            r_inst_pc   <= RESET_PC;
            r_inst      <= NOP;
            r_req       <= 1'b0;
            r_valid     <= 1'b0;
            r_trap      <= 1'b0;
            r_trap_addr <= '0;
        end else begin
            if (w_capture) begin
                r_inst    <= imem_rdata;
                r_inst_pc <= r_pc;
            end
            unique case (r_state)
                S_BOOT: begin
                    r_state <= S_REQ;
                    r_req   <= 1'b1;
                end
                S_REQ: begin
                    if (imem_gnt) begin
                        r_req <= 1'b0;
                        if (imem_rvalid) begin
                            r_state <= S_ISSUE;
                            r_valid <= 1'b1;
                        end else begin
                            r_state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        r_state <= S_ISSUE;
                        r_valid <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    if (exec_done) begin
                        r_valid <= 1'b0;
                        if (w_misalign) begin
                            r_state     <= S_TRAP;
                            r_trap      <= 1'b1;
                            r_trap_addr <= w_target;
                        end else begin
                            r_state <= S_REQ;
                            r_pc    <= w_target;
                            r_req   <= 1'b1;
                        end
                    end
                end
                S_TRAP: begin
                    r_state <= S_TRAP;
                end
                default: begin
                    r_state <= S_BOOT;
                    r_req   <= 1'b0;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req   = r_req;
    assign imem_addr  = r_pc;
    assign inst       = r_inst;
    assign inst_pc    = r_inst_pc;
    assign pc_plus4   = r_inst_pc + ADDR_W'(4);
    assign inst_valid = r_valid;
    assign trap       = r_trap;
    assign trap_addr  = r_trap_addr;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_cycle_cnt;
    logic [31:0] r_retire_cnt;
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cycle_cnt  <= '0;
            r_retire_cnt <= '0;
            r_stall_cnt  <= '0;
        end else begin
            r_cycle_cnt <= r_cycle_cnt + 32'd1;
            if ((r_state == S_ISSUE) && exec_done && !w_misalign)
                r_retire_cnt <= r_retire_cnt + 32'd1;
            if (((r_state == S_REQ) && !imem_gnt) || (r_state == S_WAIT))
                r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign cycle_cnt  = r_cycle_cnt;
    assign retire_cnt = r_retire_cnt;
    assign stall_cnt  = r_stall_cnt;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: boot, wait states, branch/jump/jalr, wrap,
// misalign trap and reset during a pending fetch.
module tb_pc_fetch_unit;

    logic        clk;
    logic        rstn;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [31:0] pc_plus4;
    logic        inst_valid;
    logic        exec_done;
    logic [2:0]  npc_op;
    logic [31:0] imm;
    logic [31:0] rs1_data;
    logic        trap;
    logic [31:0] trap_addr;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] cycle_cnt;
    logic [31:0] retire_cnt;
    logic [31:0] stall_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    pc_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_gnt   (imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .inst       (inst),
        .inst_pc    (inst_pc),
        .pc_plus4   (pc_plus4),
        .inst_valid (inst_valid),
        .exec_done  (exec_done),
        .npc_op     (npc_op),
        .imm        (imm),
        .rs1_data   (rs1_data),
`ifdef FETCH_PERF_CNT_EN
        .cycle_cnt  (cycle_cnt),
        .retire_cnt (retire_cnt),
        .stall_cnt  (stall_cnt),
`endif
        .trap       (trap),
        .trap_addr  (trap_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rstn        = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0000_0013;
        exec_done   = 1'b0;
        npc_op      = 3'b000;
        imm         = 32'h0;
        rs1_data    = 32'h0;
        repeat (3) tick();

        chk("rst_req", {31'b0, imem_req}, 32'd0);
        chk("rst_valid", {31'b0, inst_valid}, 32'd0);
        chk("rst_trap", {31'b0, trap}, 32'd0);
        chk("rst_inst", inst, 32'h0000_0013);
        chk("rst_inst_pc", inst_pc, 32'h0);
        chk("rst_trap_addr", trap_addr, 32'h0);
        chk("rst_addr", imem_addr, 32'h0);

        // Boot with zero-latency memory
        imem_gnt = 1'b1; imem_rvalid = 1'b1; exec_done = 1'b1;
        rstn = 1'b1;
        tick();
        chk("boot_req", {31'b0, imem_req}, 32'd1);
        chk("boot_addr0", imem_addr, 32'h0);
        tick();
        chk("boot_issue_valid", {31'b0, inst_valid}, 32'd1);
        chk("boot_issue_req", {31'b0, imem_req}, 32'd0);
        chk("boot_inst_pc", inst_pc, 32'h0);
        chk("boot_pc_plus4", pc_plus4, 32'h4);

        // Wait states on the request to 0x4
        imem_gnt = 1'b0; imem_rvalid = 1'b0;
        tick();
        chk("ws_req", {31'b0, imem_req}, 32'd1);
        chk("ws_addr4", imem_addr, 32'h4);
        imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        chk("ws_stray_rvalid_req", {31'b0, imem_req}, 32'd1);
        chk("ws_stray_rvalid_valid", {31'b0, inst_valid}, 32'd0);
        chk("ws_stray_rvalid_inst", inst, 32'h0000_0013);
        chk("ws_addr_held1", imem_addr, 32'h4);
        imem_rvalid = 1'b0;
        imem_gnt = 1'b1;
        tick();
        chk("ws_wait_req", {31'b0, imem_req}, 32'd0);
        chk("ws_wait_valid", {31'b0, inst_valid}, 32'd0);
        imem_gnt = 1'b0;
        tick();
        tick();
        chk("ws_wait_hold", {31'b0, inst_valid}, 32'd0);
        chk("ws_addr_held2", imem_addr, 32'h4);
        imem_rvalid = 1'b1; imem_rdata = 32'h0040_0093; exec_done = 1'b0;
        tick();
        chk("ws_valid_rise", {31'b0, inst_valid}, 32'd1);
        chk("ws_inst", inst, 32'h0040_0093);
        chk("ws_inst_pc", inst_pc, 32'h4);
        imem_rvalid = 1'b0; imem_rdata = 32'h0000_0013;
        tick();
        chk("ws_hold_valid", {31'b0, inst_valid}, 32'd1);
        chk("ws_hold_inst", inst, 32'h0040_0093);

        // Jump 0x4 -> 0x100
        imem_gnt = 1'b1; imem_rvalid = 1'b1; exec_done = 1'b1;
        npc_op = 3'b010; imm = 32'h0000_00FC;
        tick();
        chk("jmp_to_100", imem_addr, 32'h100);
        npc_op = 3'b001; imm = 32'hFFFF_FFF0;
        tick();
        chk("br_inst_pc", inst_pc, 32'h100);
        tick();
        chk("br_back", imem_addr, 32'hF0);
        npc_op = 3'b010; imm = 32'h10;
        tick();
        tick();
        chk("jmp_to_100b", imem_addr, 32'h100);
        imm = 32'h20;
        tick();
        tick();
        chk("jmp_fwd", imem_addr, 32'h120);
        imm = 32'hFFFF_FFE0;
        tick();
        tick();
        chk("jmp_to_100c", imem_addr, 32'h100);
        npc_op = 3'b011;
        tick();
        tick();
        chk("op011_plus4", imem_addr, 32'h104);

        // Wrap at top of address space
        npc_op = 3'b010; imm = 32'hFFFF_FEF8;
        tick();
        tick();
        chk("wrap_setup", imem_addr, 32'hFFFF_FFFC);
        npc_op = 3'b000;
        tick();
        chk("wrap_inst_pc", inst_pc, 32'hFFFF_FFFC);
        chk("wrap_pc_plus4", pc_plus4, 32'h0);
        tick();
        chk("wrap_addr", imem_addr, 32'h0);
        chk("wrap_no_trap", {31'b0, trap}, 32'd0);

        // JALR, then misaligned JALR trap
        npc_op = 3'b100; rs1_data = 32'h2001; imm = 32'h4;
        tick();
        tick();
        chk("jalr_addr", imem_addr, 32'h2004);
        rs1_data = 32'h2002; imm = 32'h0;
        tick();
        tick();
        chk("trap_set", {31'b0, trap}, 32'd1);
        chk("trap_addr", trap_addr, 32'h2002);
        chk("trap_valid", {31'b0, inst_valid}, 32'd0);
        for (int i = 0; i < 10; i++) begin
            chk("trap_req_low", {31'b0, imem_req}, 32'd0);
            tick();
        end
        chk("trap_pc_kept", imem_addr, 32'h2004);
        chk("trap_sticky", {31'b0, trap}, 32'd1);

        // Reset while a fetch is pending in WAIT
        rstn = 1'b0;
        #1;
        rstn = 1'b1;
        imem_rvalid = 1'b0; imem_gnt = 1'b1; npc_op = 3'b000;
        tick();
        chk("rw_req", imem_addr, 32'h0);
        tick();
        chk("rw_in_wait", {31'b0, imem_req}, 32'd0);
        rstn = 1'b0;
        #1;
        chk("rw_rst_trap", {31'b0, trap}, 32'd0);
        chk("rw_rst_trap_addr", trap_addr, 32'h0);
`ifdef FETCH_PERF_CNT_EN
        chk("rw_cycle_cnt", cycle_cnt, 32'h0);
        chk("rw_retire_cnt", retire_cnt, 32'h0);
        chk("rw_stall_cnt", stall_cnt, 32'h0);
`endif
        tick();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        rstn = 1'b1;
        tick();
        imem_rvalid = 1'b0;
        chk("rw_inst", inst, 32'h0000_0013);
        chk("rw_valid", {31'b0, inst_valid}, 32'd0);
        chk("rw_req_after", {31'b0, imem_req}, 32'd1);
        chk("rw_addr_reset_pc", imem_addr, 32'h0);
        tick();
        chk("rw_inst_still", inst, 32'h0000_0013);
        chk("rw_valid_still", {31'b0, inst_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
